// File: rtl/true_dpram_param_if.sv
// Port bundle for true_dpram_param.
//   master : drives both ports' write data, address and write enable; observes
//            registered read data, the clear-sweep busy flag and the collision pulse.
//   slave  : the RAM side of the same signals.
interface true_dpram_param_if #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 3
);
    logic [DATA_WIDTH-1:0] data_a;
    logic [ADDR_WIDTH-1:0] addr_a;
    logic                  we_a;
    logic [DATA_WIDTH-1:0] data_b;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic                  we_b;
    logic [DATA_WIDTH-1:0] q_a;
    logic [DATA_WIDTH-1:0] q_b;
    logic                  init_busy;
    logic                  collision;

    modport master (
        output data_a, addr_a, we_a, data_b, addr_b, we_b,
        input  q_a, q_b, init_busy, collision
    );

    modport slave (
        input  data_a, addr_a, we_a, data_b, addr_b, we_b,
        output q_a, q_b, init_busy, collision
    );
endinterface

// File: rtl/true_dpram_param.sv
// Single-clock true dual-port RAM with hardware clear sweep after reset.
//   clk        : clock, all state on rising edge
//   reset      : asynchronous, active-high; restarts the clear sweep
//   bus.slave  : port A/B data, address, write enable in; q_a/q_b registered
//                read data, init_busy (sweep running, ports ignored),
//                collision (one-cycle pulse, both ports wrote one address)
// Build option: define DPRAM_BYPASS_EN to forward the other port's same-cycle
// write data to a read of that address (otherwise the old word is returned).
//
// state | meaning
// INIT  | clear sweep writing INIT_VALUE to mem[sweep_cnt], ports ignored
// READY | normal dual-port operation
module true_dpram_param #(
    parameter int                    DATA_WIDTH = 12,
    parameter int                    ADDR_WIDTH = 3,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic               clk,
    input  logic               reset,
    true_dpram_param_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

`ifdef DPRAM_BYPASS_EN
    localparam bit BYPASS_EN = 1'b1;
`else
    localparam bit BYPASS_EN = 1'b0;
`endif

    typedef enum logic {INIT, READY} state_t;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] sweep_cnt;
    logic [ADDR_WIDTH-1:0] sweep_cnt_next;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  ready;
    logic                  collide;
    logic                  wr_a;
    logic                  wr_b;
    logic [DATA_WIDTH-1:0] q_a_next;
    logic [DATA_WIDTH-1:0] q_b_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= INIT;
            sweep_cnt <= '0;
        end else begin
            state     <= state_next;
            sweep_cnt <= sweep_cnt_next;
        end
    end

    // The counter wraps to 0 naturally on the last sweep write.
    always_comb begin
        state_next     = state;
        sweep_cnt_next = sweep_cnt;
        case (state)
            INIT: begin
                sweep_cnt_next = sweep_cnt + ADDR_WIDTH'(1);
                if (sweep_cnt == ADDR_WIDTH'(DEPTH - 1))
                    state_next = READY;
            end
            READY: ;
            default: state_next = INIT;
        endcase
    end

    always_comb begin
        ready         = (state == READY);
        bus.init_busy = (state == INIT);
        collide       = ready && bus.we_a && bus.we_b && (bus.addr_a == bus.addr_b);
        wr_a          = ready && bus.we_a;
        // Port A wins a same-address collision; the B write is dropped.
        wr_b          = ready && bus.we_b && !collide;

        q_a_next = '0;
        q_b_next = '0;
        if (ready) begin
            if (bus.we_a)
                q_a_next = bus.data_a;
            else if (BYPASS_EN && bus.we_b && (bus.addr_b == bus.addr_a))
                q_a_next = bus.data_b;
            else
                q_a_next = mem[bus.addr_a];

            if (collide)
                q_b_next = bus.data_a;
            else if (bus.we_b)
                q_b_next = bus.data_b;
            else if (BYPASS_EN && bus.we_a && (bus.addr_a == bus.addr_b))
                q_b_next = bus.data_a;
            else
                q_b_next = mem[bus.addr_b];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.q_a       <= '0;
            bus.q_b       <= '0;
            bus.collision <= 1'b0;
        end else begin
            bus.q_a       <= q_a_next;
            bus.q_b       <= q_b_next;
            bus.collision <= collide;
        end
    end

    // No reset on the array; gating on reset drops any write at an edge
    // that sees reset high.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == INIT) begin
                mem[sweep_cnt] <= INIT_VALUE;
            end else begin
                if (wr_a) mem[bus.addr_a] <= bus.data_a;
                if (wr_b) mem[bus.addr_b] <= bus.data_b;
            end
        end
    end
endmodule

// File: doc/true_dpram_param.md
# true_dpram_param

Parametrised single-clock true dual-port RAM: the next generation of the 8×12 dual-port memory used in the transaction-layer buffers. Width and depth are parametrised. An asynchronous reset triggers a hardware clear sweep over every location. Same-address write collisions are resolved deterministically and flagged. Optional cross-port read bypass. Sits under the transaction-layer FIFOs as their storage element.

## Interface
- DATA_WIDTH, 12, bits per word
- ADDR_WIDTH, 3, address bits; DEPTH = 2**ADDR_WIDTH words
- INIT_VALUE, 0, word written to every location by the clear sweep (DATA_WIDTH bits)

- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- data_a  in  DATA_WIDTH  port A write data
- addr_a  in  ADDR_WIDTH  port A address
- we_a  in  1  port A write enable
- data_b  in  DATA_WIDTH  port B write data
- addr_b  in  ADDR_WIDTH  port B address
- we_b  in  1  port B write enable
- q_a  out  DATA_WIDTH  port A registered read data
- q_b  out  DATA_WIDTH  port B registered read data
- init_busy  out  1  clear sweep in progress; ports ignored while high
- collision  out  1  one-cycle pulse: both ports wrote the same address last edge

## Operation
- FSM states: INIT, READY.
- Reset asserted (async): state=INIT, sweep counter=0, q_a=q_b=0, init_busy=1, collision=0. Memory contents are not touched by the async event itself.
- INIT:
  - Each edge writes INIT_VALUE to mem[counter]; counter increments.
  - we_a/we_b and addresses are ignored; q_a, q_b held 0; collision=0.
  - On the edge that writes address DEPTH-1: state→READY, init_busy→0, counter wraps to 0.
- READY, per port X in {A,B}, every edge:
  - we_x=0: q_x <= mem[addr_x].
  - we_x=1: mem[addr_x] <= data_x and q_x <= data_x (write-first on the own port).
- Both ports write the same address (we_a=we_b=1, addr_a==addr_b):
  - Port A wins: mem gets data_a and the B write is dropped.
  - q_a <= data_a, q_b <= data_a.
  - collision=1 for that cycle. collision is 0 otherwise.
- Both ports write different addresses: both writes commit, with no interaction.
- One port reads the address the other port writes in the same cycle: see Configuration.
- Both ports read the same address: both get the same stored word.
- Address arithmetic: addresses are unsigned ADDR_WIDTH bits, so all DEPTH values are legal and there is no out-of-range case.

## Timing
- Read latency is 1 cycle: address at edge N, q valid after edge N, stable until edge N+1.
- Write takes effect at the edge. A read of that address at edge N+1 returns the new data.
- Clear sweep timing, taking edge 1 as the first rising edge with reset low:
  - The sweep occupies edges 1..DEPTH.
  - init_busy goes low after edge DEPTH.
  - The first port operation is accepted at edge DEPTH+1.
- Reset asserted mid-sweep or mid-operation:
  - Outputs go immediately to reset values.
  - An in-flight write at that edge is lost.
  - After release, the sweep restarts from address 0 and runs a full DEPTH cycles.
- collision is registered and aligned with the q update of the colliding edge.

## Configuration
- DPRAM_BYPASS_EN defined: a cross-port read of an address being written by the other port in the same cycle returns the new write data (q_b <= data_a, or q_a <= data_b).
- DPRAM_BYPASS_EN undefined: that read returns the old stored word (read-before-write across ports).
- Either way, memory contents after the edge are identical, and same-port and collision behaviour is unchanged.

## Test plan
All scenarios use DATA_WIDTH=12, ADDR_WIDTH=3, INIT_VALUE=12'h000.
- Reset release, then read every address on both ports:
  - init_busy high for exactly 8 edges.
  - All reads return 12'h000.
  - q_a=q_b=0 throughout INIT.
- Write A addr 3 = 12'hABC, next cycle read B addr 3 -> q_b=12'hABC one cycle later. Same-port write A addr 5 = 12'h123 -> q_a=12'h123 at that edge.
- Same-cycle writes A addr 2 = 12'h111, B addr 2 = 12'h222:
  - collision=1 for one cycle.
  - q_a=q_b=12'h111.
  - A later read of addr 2 returns 12'h111.
- mem[6]=12'h0F0; in the same cycle A writes addr 6 = 12'hF0F and B reads addr 6:
  - Bypass undefined -> q_b=12'h0F0.
  - Bypass defined -> q_b=12'hF0F.
  - Both builds: a subsequent read returns 12'hF0F.
- Fill all 8 addresses, then assert reset mid-operation at an arbitrary phase:
  - q outputs clear asynchronously.
  - After release, init_busy is high 8 edges.
  - All locations read 12'h000.
- During INIT, drive we_a=we_b=1 with data 12'hFFF to addr 0:
  - No effect; addr 0 reads 12'h000 after the sweep.
  - collision stays 0.
